shift64: RTL and testbench

SHIFT64 -- requirements
Module: shift64

---
 rtl/shift64.sv | 91 +++++++++
 tb/tb_shift64.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift64.sv
// ============================================================================
// Module      : shift64
// Description : Registered 64-bit shifter. Works as one 64-bit shift or as two
//               independent 32-bit lane shifts.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mode_unified,
    input  logic        uni_dir,
    input  logic        uni_arith,
    input  logic [11:0] shift_amt,
    input  logic        hi_dir,
    input  logic        hi_arith,
    input  logic        lo_dir,
    input  logic        lo_arith,
    input  logic [63:0] in_bus,
    output logic [63:0] out_bus,
    output logic        out_valid
);

    // A 6-bit amount can reach 63, so a lane shift of 32..63 naturally
    // saturates to zero or to the sign bit through the language operators.
    function automatic logic [31:0] shift_lane32(
        input logic [31:0] operand,
        input logic [5:0]  amt,
        input logic        dir,
        input logic        arith
    );
        logic [31:0] result;
        if (!dir)
            result = operand << amt;
        else if (arith)
            result = $signed(operand) >>> amt;
        else
            result = operand >> amt;
        return result;
    endfunction

    function automatic logic [63:0] shift_word64(
        input logic [63:0] operand,
        input logic [5:0]  amt,
        input logic        dir,
        input logic        arith
    );
        logic [63:0] result;
        if (!dir)
            result = operand << amt;
        else if (arith)
            result = $signed(operand) >>> amt;
        else
            result = operand >> amt;
        return result;
    endfunction

    logic [63:0] w_uni_result;
    logic [31:0] w_hi_result;
    logic [31:0] w_lo_result;
    logic [63:0] w_next_bus;
    logic [63:0] r_out_bus;
    logic        r_out_valid;

    always_comb begin
        w_uni_result = shift_word64(in_bus, shift_amt[5:0], uni_dir, uni_arith);
        w_hi_result  = shift_lane32(in_bus[63:32], shift_amt[11:6], hi_dir, hi_arith);
        w_lo_result  = shift_lane32(in_bus[31:0],  shift_amt[5:0],  lo_dir, lo_arith);
        w_next_bus   = mode_unified ? w_uni_result : {w_hi_result, w_lo_result};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bus   <= 64'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid)
                r_out_bus <= w_next_bus;
        end
    end

    assign out_bus   = r_out_bus;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_shift64.sv
// ============================================================================
// Module      : tb_shift64
// Description : Directed self-checking bench for shift64.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        mode_unified;
    logic        uni_dir;
    logic        uni_arith;
    logic [11:0] shift_amt;
    logic        hi_dir;
    logic        hi_arith;
    logic        lo_dir;
    logic        lo_arith;
    logic [63:0] in_bus;
    logic [63:0] out_bus;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    shift64 u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .mode_unified (mode_unified),
        .uni_dir      (uni_dir),
        .uni_arith    (uni_arith),
        .shift_amt    (shift_amt),
        .hi_dir       (hi_dir),
        .hi_arith     (hi_arith),
        .lo_dir       (lo_dir),
        .lo_arith     (lo_arith),
        .in_bus       (in_bus),
        .out_bus      (out_bus),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %016h expected %016h", tag, got, exp);
        end
    endtask

    // Unified op: hi/lo controls driven as the inverse of the unified ones.
    task automatic apply_uni(input logic dir, input logic arith, input logic [5:0] amt,
                             input logic [63:0] data);
        in_valid     = 1'b1;
        mode_unified = 1'b1;
        uni_dir      = dir;
        uni_arith    = arith;
        shift_amt    = {~amt, amt};
        hi_dir       = ~dir;
        hi_arith     = ~arith;
        lo_dir       = ~dir;
        lo_arith     = ~arith;
        in_bus       = data;
    endtask

    task automatic apply_split(input logic hd, input logic ha, input logic [5:0] hamt,
                               input logic ld, input logic la, input logic [5:0] lamt,
                               input logic ud, input logic ua, input logic [63:0] data);
        in_valid     = 1'b1;
        mode_unified = 1'b0;
        uni_dir      = ud;
        uni_arith    = ua;
        shift_amt    = {hamt, lamt};
        hi_dir       = hd;
        hi_arith     = ha;
        lo_dir       = ld;
        lo_arith     = la;
        in_bus       = data;
    endtask

    task automatic step_and_check(input string tag, input logic [63:0] exp);
        @(posedge clk);
        #1;
        check({tag, "_data"}, out_bus, exp);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        mode_unified = 1'b0;
        uni_dir      = 1'b0;
        uni_arith    = 1'b0;
        shift_amt    = 12'd0;
        hi_dir       = 1'b0;
        hi_arith     = 1'b0;
        lo_dir       = 1'b0;
        lo_arith     = 1'b0;
        in_bus       = 64'h0;

        #2;
        check("reset_data", out_bus, 64'h0);
        check("reset_valid", {63'd0, out_valid}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream, one result per cycle.
        apply_split(1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0, 64'hFEDCBA9876543210);
        step_and_check("split_ra2_l3", 64'hFFB72EA6B2A19080);
        apply_split(1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 64'hFEDCBA9876543210);
        step_and_check("split_l1_rl4", 64'hFDB9753007654321);
        apply_uni(1'b0, 1'b0, 6'd0, 64'hFEDCBA9876543210);
        step_and_check("uni_l0", 64'hFEDCBA9876543210);
        apply_uni(1'b0, 1'b1, 6'd4, 64'hFEDCBA9876543210);
        step_and_check("uni_l4_arith_ignored", 64'hEDCBA98765432100);
        apply_uni(1'b0, 1'b0, 6'd40, 64'hFEDCBA9876543210);
        step_and_check("uni_l40", 64'h5432100000000000);
        apply_uni(1'b1, 1'b0, 6'd35, 64'hFEDCBA9876543210);
        step_and_check("uni_rl35", 64'h000000001FDB9753);
        apply_uni(1'b1, 1'b1, 6'd10, 64'hF0000000A0000000);
        step_and_check("uni_ra10", 64'hFFFC000000280000);
        apply_uni(1'b1, 1'b1, 6'd63, 64'hF0000000A0000000);
        step_and_check("uni_ra63", 64'hFFFFFFFFFFFFFFFF);
        apply_uni(1'b1, 1'b1, 6'd4, 64'h7000000000000000);
        step_and_check("uni_ra4_pos", 64'h0700000000000000);
        // Lane amounts beyond the lane width saturate without crossing lanes.
        apply_split(1'b0, 1'b0, 6'd32, 1'b1, 1'b1, 6'd40, 1'b0, 1'b0, 64'h1234567880000000);
        step_and_check("split_l32_ra40", 64'h00000000FFFFFFFF);
        apply_split(1'b1, 1'b1, 6'd63, 1'b1, 1'b0, 6'd63, 1'b0, 1'b1, 64'h80000000FFFFFFFF);
        step_and_check("split_ra63_rl63", 64'hFFFFFFFF00000000);
        apply_split(1'b1, 1'b1, 6'd0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 64'h89ABCDEF01234567);
        step_and_check("split_amt0", 64'h89ABCDEF01234567);
        apply_split(1'b1, 1'b0, 6'd8, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0, 64'h8000000180000001);
        step_and_check("split_rl8_ra8", 64'h00800000FF800000);

        // Hold: with in_valid low the result stays and out_valid drops.
        in_valid = 1'b0;
        in_bus   = 64'hDEADBEEFDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        check("hold_data", out_bus, 64'h00800000FF800000);
        check("hold_valid", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset mid-stream, away from any clock edge.
        apply_uni(1'b0, 1'b0, 6'd4, 64'h0000000000000011);
        step_and_check("pre_reset", 64'h0000000000000110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data", out_bus, 64'h0);
        check("async_reset_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_data", out_bus, 64'h0);
        check("post_reset_valid", {63'd0, out_valid}, 64'd0);

        // First capture after reset release.
        apply_uni(1'b1, 1'b0, 6'd4, 64'h0000000000000110);
        step_and_check("first_after_reset", 64'h0000000000000011);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
